proc_param: RTL
===============

# proc_param

Parametrised multicycle processor: next generation of the team's 9-bit bus-based datapath (register file, A/G registers, single shared bus, step-counter FSM). Data width and register count are generic. The ALU set adds AND, XOR and a conditional move, with carry/zero flags. All state resets cleanly. Sits under the board top level, fed by the instruction source on `DIN` and qualified by `Run`.

## Interface
- `DW`, 9: data/bus width; must satisfy `DW >= 3 + 2*RW`.
- `NREG`, 8: number of general registers; power of two, 2..16.
- `RW`, `$clog2(NREG)`: register-index width (derived, not overridden).
- `Clock`  in  1  sole clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `DIN`  in  DW  instruction word in T0; immediate data in T1 of MVI.
- `Run`  in  1  start request, sampled only in T0.
- `Done`  out  1  high during the final step of each instruction.
- `BusWires`  out  DW  shared bus value.
- `Tstep_Q`  out  2  current step (T0..T3).
- `Flags`  out  2  {C, Z}.
- `Rflat`  out  NREG*DW  register file, R0 in LSBs.

## Operation
- Instruction word: `IR[3+2RW-1 -: 3]` = opcode, then X field (RW bits), then Y field (RW bits) in the LSBs. Upper unused bits are ignored.
- Opcodes:
  - 000 MV Rx←Ry
  - 001 MVI Rx←DIN
  - 010 ADD Rx←Rx+Ry
  - 011 SUB Rx←Rx−Ry
  - 100 AND
  - 101 XOR
  - 110 MVNZ Rx←Ry if G≠0
  - 111 reserved (NOP)
- Bus mux is one-hot across Ry/Rx, DIN and G. With no source selected, the bus is 0.
- Step FSM:
  - T0: IR←DIN when Run=1, go to T1; else stay in T0.
  - T1: MV/MVI/MVNZ/NOP complete here (Done=1) → T0. ALU ops: A←Rx → T2.
  - T2: G←A op Ry, flags update → T3.
  - T3: Rx←G, Done=1 → T0.
- Arithmetic is modulo 2^DW.
  - ADD: C = carry out.
  - SUB: C = borrow (Rx<Ry unsigned).
  - AND/XOR: C=0.
  - Z = (result==0).
- Flags change only when G loads.
- MVNZ tests G as held from the previous ALU instruction.
- X=Y is legal; e.g. ADD R3,R3 doubles R3.

## Timing
- Latency, Run sampled in T0 to Done:
  - MV, MVI, MVNZ, NOP: 2 cycles (T0,T1).
  - ADD, SUB, AND, XOR: 4 cycles (T0..T3).
- Done is combinational from Tstep_Q and IR, high exactly one cycle per instruction. The destination write lands on the clock edge ending that cycle.
- Run is ignored in T1–T3.
- Run held high issues back-to-back instructions: T0 follows every Done with no extra bubble.
- MVI: DIN must hold the immediate during T1.
- Reset values: Tstep_Q=T0; IR, A, G, all Rk, Flags = 0. Done=0 and BusWires=0 while in reset.
- Reset mid-instruction aborts it. No register or flag write occurs, and the first post-reset edge with Run=1 fetches a fresh instruction.

## Configuration
- `PROC_ISA_EXT_EN` defined: AND (100), XOR (101) and MVNZ (110) are implemented as above.
- Undefined: opcodes 100–110 behave as 111, a 2-cycle NOP with Done in T1. No register, A, G or flag change occurs. The ALU reduces to add/sub only.

## Test plan
- Reset, then MVI R0 (DIN=9'b001_000_000 in T0, DIN=5 in T1) → Done in cycle 2, R0=5; then MV R1,R0 → R1=5 after 2 cycles, Flags unchanged {0,0}.
- R0=5, R1=10, ADD R0,R1 → Done only in T3, R0=15, Flags={0,0}. Then R2=511, R3=1, ADD R2,R3 → R2=0, Flags={1,1}.
- R0=5, R1=10, SUB R0,R1 → R0=507 (9'h1FB), C=1, Z=0.
- With `PROC_ISA_EXT_EN`:
  - R4=9'h0F0, R5=9'h03C, AND R4,R5 → R4=9'h030.
  - XOR R4,R4 → R4=0, Z=1.
  - MVNZ R6,R5 → R6 unchanged (G=0).
  - After ADD yielding 3, MVNZ R6,R5 → R6=9'h03C.
  - Without the macro: same AND stimulus → Done in T1, R4 stays 9'h0F0.
- Run held high across 3 back-to-back MVIs → Done pulses in cycles 2, 4, 6, with Tstep_Q sequence 0,1,0,1,0,1.
- Reset asserted during T2 of ADD R0,R1 → Tstep_Q=0, all Rk=0, Done=0 immediately. After release with Run=0, no register changes for 10 cycles.

Source files
------------

// File: rtl/proc_param.sv
// Parametrised bus-based multicycle processor; `PROC_ISA_EXT_EN enables AND/XOR/MVNZ.
// Latency: 2 cycles (moves/NOP) or 4 cycles (ALU ops) from Run in T0 to Done; no backpressure, Run only sampled in T0.
module proc_param #(
   parameter int DW   = 9,
   parameter int NREG = 8
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic [DW-1:0]        DIN,
   input  logic                 Run,
   output logic                 Done,
   output logic [DW-1:0]        BusWires,
   output logic [1:0]           Tstep_Q,
   output logic [1:0]           Flags,
   output logic [NREG*DW-1:0]   Rflat
);
   localparam int RW = $clog2(NREG);

   typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} tstep_t;

   tstep_t         r_step, w_step_nxt;
   logic [DW-1:0]  r_ir, r_a, r_g;
   logic           r_c, r_z;
   logic [DW-1:0]  r_reg [NREG];

   logic [2:0]     w_op;
   logic [RW-1:0]  w_x, w_y;
   logic           w_alu_op, w_mvnz;
   logic           w_sel_ry, w_sel_rx, w_sel_din, w_sel_g;
   logic           w_ld_ir, w_ld_a, w_ld_g, w_wr_en;
   logic [DW-1:0]  w_bus, w_alu_res;
   logic           w_alu_c;

   assign w_op = r_ir[3+2*RW-1 -: 3];
   assign w_x  = r_ir[2*RW-1 -: RW];
   assign w_y  = r_ir[RW-1:0];

`ifdef PROC_ISA_EXT_EN
   assign w_alu_op = (w_op == 3'b010) || (w_op == 3'b011) || (w_op == 3'b100) || (w_op == 3'b101);
   assign w_mvnz   = (w_op == 3'b110);
`else
   assign w_alu_op = (w_op == 3'b010) || (w_op == 3'b011);
   assign w_mvnz   = 1'b0;
`endif

   always_comb begin
      w_step_nxt = r_step;
      Done       = 1'b0;
      w_sel_ry   = 1'b0;
      w_sel_rx   = 1'b0;
      w_sel_din  = 1'b0;
      w_sel_g    = 1'b0;
      w_ld_ir    = 1'b0;
      w_ld_a     = 1'b0;
      w_ld_g     = 1'b0;
      w_wr_en    = 1'b0;
      case (r_step)
         T0: begin
            // IR loads straight from DIN so the bus stays quiet while idle or in reset
            if (Run) begin
               w_ld_ir    = 1'b1;
               w_step_nxt = T1;
            end
         end
         T1: begin
            if (w_alu_op) begin
               w_sel_rx   = 1'b1;
               w_ld_a     = 1'b1;
               w_step_nxt = T2;
            end else begin
               Done       = 1'b1;
               w_step_nxt = T0;
               case (w_op)
                  3'b000: begin w_sel_ry = 1'b1; w_wr_en = 1'b1; end
                  3'b001: begin w_sel_din = 1'b1; w_wr_en = 1'b1; end
                  default: begin
                     if (w_mvnz) begin
                        w_sel_ry = 1'b1;
                        w_wr_en  = (r_g != '0);
                     end
                  end
               endcase
            end
         end
         T2: begin
            w_sel_ry   = 1'b1;
            w_ld_g     = 1'b1;
            w_step_nxt = T3;
         end
         T3: begin
            w_sel_g    = 1'b1;
            w_wr_en    = 1'b1;
            Done       = 1'b1;
            w_step_nxt = T0;
         end
         default: w_step_nxt = T0;
      endcase
   end

   assign w_bus = ({DW{w_sel_ry}}  & r_reg[w_y]) |
                  ({DW{w_sel_rx}}  & r_reg[w_x]) |
                  ({DW{w_sel_din}} & DIN)        |
                  ({DW{w_sel_g}}   & r_g);

   always_comb begin
      w_alu_res = '0;
      w_alu_c   = 1'b0;
      case (w_op)
         3'b010: {w_alu_c, w_alu_res} = {1'b0, r_a} + {1'b0, w_bus};
         3'b011: begin
            w_alu_res = r_a - w_bus;
            w_alu_c   = (r_a < w_bus);
         end
`ifdef PROC_ISA_EXT_EN
         3'b100: w_alu_res = r_a & w_bus;
         3'b101: w_alu_res = r_a ^ w_bus;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) r_step <= T0;
      else       r_step <= w_step_nxt;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_ir <= '0;
         r_a  <= '0;
         r_g  <= '0;
         r_c  <= 1'b0;
         r_z  <= 1'b0;
         for (int k = 0; k < NREG; k++) r_reg[k] <= '0;
      end else begin
         if (w_ld_ir) r_ir <= DIN;
         if (w_ld_a)  r_a  <= w_bus;
         if (w_ld_g) begin
            r_g <= w_alu_res;
            r_c <= w_alu_c;
            r_z <= (w_alu_res == '0);
         end
         if (w_wr_en) r_reg[w_x] <= w_bus;
      end
   end

   genvar g_k;
   generate
      for (g_k = 0; g_k < NREG; g_k++) begin : g_flat
         assign Rflat[g_k*DW +: DW] = r_reg[g_k];
      end
   endgenerate

   assign BusWires = w_bus;
   assign Tstep_Q  = r_step;
   assign Flags    = {r_c, r_z};

endmodule
